nmr_bstrm_arb_encoder: RTL and testbench

//  Captures a serial bitstream on IN, one sample per CLK, and compresses it into the bitstream command words played back by the

---
 rtl/nmr_bstrm_arb_encoder.sv | 222 ++++++++++++++++++++++
 tb/tb_nmr_bstrm_arb_encoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nmr_bstrm_arb_encoder.sv
// Serial bitstream capture encoder: compresses sampled IN into run words (all_0/all_1),
// raw pattern words and a terminating end_of_sequence word, through a one-deep output register.
//
// state | meaning
// IDLE  | waiting for START, DONE=1
// FILL  | collecting samples into the pattern window
// RUN   | counting a uniform run beyond one full window
// FLUSH | emitting the residual run/pattern word after STOP
// EOS   | emitting end_of_sequence and waiting for it to be accepted
module nmr_bstrm_arb_encoder #(
  parameter int DATA_WIDTH = 120
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  IN,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  pattern_mode,
  output logic                  all_1_mode,
  output logic                  all_0_mode,
  output logic                  end_of_sequence,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVF
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] MODE_PAT = 4'b1000;
  localparam logic [3:0] MODE_A1  = 4'b0100;
  localparam logic [3:0] MODE_A0  = 4'b0010;
  localparam logic [3:0] MODE_EOS = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    EOS
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] window;
  logic [CW-1:0]         count;
  logic                  mixed;
  logic [DATA_WIDTH-1:0] run_cnt;
  logic                  level;
  logic                  in_run;
  logic                  eos_sent;

  logic [DATA_WIDTH-1:0] win_sample;
  logic                  mixed_sample;
  logic [CW-1:0]         cnt_inc;
  logic                  fill_done;
  logic [DATA_WIDTH-1:0] run_inc;
  logic                  run_sat;
  logic                  free;
  logic                  consume;
  logic                  ld_req;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [3:0]            ld_mode;

  always_comb begin
    win_sample   = window | ({{(DATA_WIDTH-1){1'b0}}, IN} << count);
    mixed_sample = mixed | ((count != '0) && (IN != window[0]));
    cnt_inc      = count + 1'b1;
    fill_done    = (cnt_inc == CW'(DATA_WIDTH));
    run_inc      = run_cnt + 1'b1;
    run_sat      = (run_inc == {DATA_WIDTH{1'b1}});
    free         = !OUT_VALID || OUT_READY;
    consume      = OUT_VALID && OUT_READY;
  end

  // Word to load this edge; FILL/RUN may request into a full register (dropped), FLUSH/EOS only when free.
  always_comb begin
    ld_req  = 1'b0;
    ld_data = '0;
    ld_mode = 4'b0000;
    case (state)
      FILL: begin
        if (fill_done && mixed_sample) begin
          ld_req  = 1'b1;
          ld_data = win_sample;
          ld_mode = MODE_PAT;
        end
      end
      RUN: begin
        if (IN != level) begin
          ld_req  = 1'b1;
          ld_data = run_cnt;
          ld_mode = level ? MODE_A1 : MODE_A0;
        end else if (run_sat) begin
          ld_req  = 1'b1;
          ld_data = run_inc;
          ld_mode = level ? MODE_A1 : MODE_A0;
        end
      end
      FLUSH: begin
        if (free && in_run) begin
          ld_req  = 1'b1;
          ld_data = run_cnt;
          ld_mode = level ? MODE_A1 : MODE_A0;
        end else if (free && count != '0) begin
          ld_req  = 1'b1;
          ld_data = window;
          ld_mode = MODE_PAT;
        end
      end
      EOS: begin
        if (free && !eos_sent) begin
          ld_req  = 1'b1;
          ld_mode = MODE_EOS;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      window          <= '0;
      count           <= '0;
      mixed           <= 1'b0;
      run_cnt         <= '0;
      level           <= 1'b0;
      in_run          <= 1'b0;
      eos_sent        <= 1'b0;
      data            <= '0;
      pattern_mode    <= 1'b0;
      all_1_mode      <= 1'b0;
      all_0_mode      <= 1'b0;
      end_of_sequence <= 1'b0;
      OUT_VALID       <= 1'b0;
      BUSY            <= 1'b0;
      DONE            <= 1'b1;
      OVF             <= 1'b0;
    end else begin
      if (ld_req && free) begin
        data <= ld_data;
        {pattern_mode, all_1_mode, all_0_mode, end_of_sequence} <= ld_mode;
        OUT_VALID <= 1'b1;
      end else if (consume) begin
        OUT_VALID <= 1'b0;
      end
      if (ld_req && !free) OVF <= 1'b1;

      case (state)
        IDLE: begin
          if (START) begin
            state    <= FILL;
            window   <= '0;
            count    <= '0;
            mixed    <= 1'b0;
            in_run   <= 1'b0;
            eos_sent <= 1'b0;
            OVF      <= 1'b0;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
          end
        end
        FILL: begin
          if (fill_done) begin
            window <= '0;
            count  <= '0;
            mixed  <= 1'b0;
            if (!mixed_sample) begin
              state   <= RUN;
              in_run  <= 1'b1;
              run_cnt <= DATA_WIDTH'(DATA_WIDTH);
              level   <= win_sample[0];
            end
          end else begin
            window <= win_sample;
            count  <= cnt_inc;
            mixed  <= mixed_sample;
          end
          if (STOP) state <= FLUSH;
        end
        RUN: begin
          if (IN != level) begin
            state  <= FILL;
            in_run <= 1'b0;
            window <= {{(DATA_WIDTH-1){1'b0}}, IN};
            count  <= CW'(1);
            mixed  <= 1'b0;
          end else if (run_sat) begin
            state  <= FILL;
            in_run <= 1'b0;
            window <= '0;
            count  <= '0;
            mixed  <= 1'b0;
          end else begin
            run_cnt <= run_inc;
          end
          if (STOP) state <= FLUSH;
        end
        FLUSH: begin
          if (free) begin
            state  <= EOS;
            in_run <= 1'b0;
            count  <= '0;
          end
        end
        EOS: begin
          if (!eos_sent) begin
            if (free) eos_sent <= 1'b1;
          end else if (consume) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmr_bstrm_arb_encoder.sv
// Directed bench for nmr_bstrm_arb_encoder at DATA_WIDTH=8: table of short captures plus
// hand-written run, overflow, saturation and mid-capture reset sequences.
module tb_nmr_bstrm_arb_encoder;

  localparam logic [3:0] PAT = 4'b1000;
  localparam logic [3:0] A1  = 4'b0100;
  localparam logic [3:0] A0  = 4'b0010;
  localparam logic [3:0] EW  = 4'b0001;

  logic       CLK, RST, START, STOP, IN, OUT_READY;
  logic [7:0] data;
  logic       pattern_mode, all_1_mode, all_0_mode, end_of_sequence;
  logic       OUT_VALID, BUSY, DONE, OVF;

  nmr_bstrm_arb_encoder #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .IN(IN),
    .data(data), .pattern_mode(pattern_mode), .all_1_mode(all_1_mode),
    .all_0_mode(all_0_mode), .end_of_sequence(end_of_sequence),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // accepted words, {pattern, all_1, all_0, eos, data}
  logic [11:0] words[$];
  always @(posedge CLK)
    if (OUT_VALID && OUT_READY)
      words.push_back({pattern_mode, all_1_mode, all_0_mode, end_of_sequence, data});

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic feed(input logic b, input logic stp);
    @(negedge CLK);
    IN = b;
    STOP = stp;
    @(posedge CLK);
    #1;
    STOP = 1'b0;
  endtask

  task automatic start_cap();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!DONE && i < 60) begin
      @(posedge CLK);
      #1;
      i++;
    end
    check(name, DONE, 1'b1);
  endtask

  task automatic check_words(input string name, input int n, input logic [11:0] w0,
                             input logic [11:0] w1, input logic [11:0] w2);
    check({name, "_nwords"}, words.size(), n);
    if (words.size() > 0) check({name, "_w0"}, words[0], w0);
    if (words.size() > 1 && n > 1) check({name, "_w1"}, words[1], w1);
    if (words.size() > 2 && n > 2) check({name, "_w2"}, words[2], w2);
  endtask

  typedef struct {
    logic [7:0]  bits;
    int          n;
    logic        exp_v;
    logic [11:0] exp_w;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h4D, 8, 1'b1, {PAT, 8'h4D}};
    vecs[1] = '{8'h03, 3, 1'b0, {PAT, 8'h03}};
    vecs[2] = '{8'hFF, 8, 1'b0, {A1, 8'd8}};
    vecs[3] = '{8'h00, 8, 1'b0, {A0, 8'd8}};
    vecs[4] = '{8'h01, 1, 1'b0, {PAT, 8'h01}};
    vecs[5] = '{8'h0A, 5, 1'b0, {PAT, 8'h0A}};
    vecs[6] = '{8'h80, 8, 1'b1, {PAT, 8'h80}};
    vecs[7] = '{8'h00, 2, 1'b0, {PAT, 8'h00}};

    RST = 1'b1; START = 1'b0; STOP = 1'b0; IN = 1'b0; OUT_READY = 1'b1;
    #12;
    check("rst_done", DONE, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_valid", OUT_VALID, 1'b0);
    check("rst_ovf", OVF, 1'b0);
    check("rst_data", data, 8'h00);
    @(negedge CLK);
    RST = 1'b0;

    // table: each capture stops on its last sample, expect one word then EOS
    for (int v = 0; v < 8; v++) begin
      words.delete();
      start_cap();
      check($sformatf("v%0d_busy", v), {BUSY, DONE}, 2'b10);
      for (int j = 0; j < vecs[v].n; j++) begin
        if (j == vecs[v].n - 1 && vecs[v].n == 8)
          check($sformatf("v%0d_prevalid", v), OUT_VALID, 1'b0);
        feed(vecs[v].bits[j], j == vecs[v].n - 1);
      end
      check($sformatf("v%0d_valid_lat", v), OUT_VALID, vecs[v].exp_v);
      check($sformatf("v%0d_notdone", v), DONE, 1'b0);
      wait_done($sformatf("v%0d_done", v));
      check_words($sformatf("v%0d", v), 2, vecs[v].exp_w, {EW, 8'h00}, 12'h000);
    end

    // 20 ones then a 0 carrying STOP: run word on the 0 edge, then single-sample residual
    words.delete();
    start_cap();
    for (int j = 0; j < 20; j++) feed(1'b1, 1'b0);
    check("run20_novalid", OUT_VALID, 1'b0);
    feed(1'b0, 1'b1);
    check("run20_word", {OUT_VALID, all_1_mode, data}, {1'b1, 1'b1, 8'd20});
    wait_done("run20_done");
    check_words("run20", 3, {A1, 8'd20}, {PAT, 8'h00}, {EW, 8'h00});

    // overflow: consumer stalled, second pattern dropped, flush stalls without further drop
    words.delete();
    OUT_READY = 1'b0;
    start_cap();
    for (int j = 0; j < 16; j++) feed(~j[0], j == 15);
    check("ovf_set", OVF, 1'b1);
    check("ovf_held", {OUT_VALID, pattern_mode, data}, {1'b1, 1'b1, 8'h55});
    repeat (5) @(posedge CLK);
    #1;
    check("ovf_stall", {BUSY, DONE, OUT_VALID, data}, {1'b1, 1'b0, 1'b1, 8'h55});
    @(negedge CLK);
    OUT_READY = 1'b1;
    wait_done("ovf_done");
    check_words("ovf", 2, {PAT, 8'h55}, {EW, 8'h00}, 12'h000);
    check("ovf_sticky", OVF, 1'b1);
    start_cap();
    check("ovf_cleared", OVF, 1'b0);

    // asynchronous reset mid-run, then a clean capture
    RST = 1'b1;
    #2;
    @(negedge CLK);
    RST = 1'b0;
    words.delete();
    start_cap();
    for (int j = 0; j < 12; j++) feed(1'b0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("mrst_out", {DONE, BUSY, OUT_VALID, OVF, data}, {4'b1000, 8'h00});
    @(negedge CLK);
    RST = 1'b0;
    start_cap();
    feed(1'b1, 1'b0);
    feed(1'b1, 1'b0);
    feed(1'b0, 1'b1);
    wait_done("mrst_done");
    check_words("mrst", 2, {PAT, 8'h03}, {EW, 8'h00}, 12'h000);

    // saturated run: 255 ones give one maximal word, the next 8 ones form a fresh run
    words.delete();
    start_cap();
    for (int j = 0; j < 263; j++) feed(1'b1, j == 262);
    wait_done("sat_done");
    check_words("sat", 3, {A1, 8'd255}, {A1, 8'd8}, {EW, 8'h00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
